// File: rtl/piso_shift_ctrl_if.sv
// Handshake and serial-link bundle for piso_shift_ctrl.
// The master side is whoever supplies words and drives ser_in; the slave side is the serialiser itself.
interface piso_shift_ctrl_if #(
  parameter int WIDTH = 8
);
  localparam int IW = $clog2(WIDTH);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             ser_in;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic [IW-1:0]    bit_idx;
  logic             done;
  logic [WIDTH-1:0] par_out;

  modport master (
    output load_valid, load_data, ser_in,
    input  load_ready, ser_out, ser_valid, busy, bit_idx, done, par_out
  );

  modport slave (
    input  load_valid, load_data, ser_in,
    output load_ready, ser_out, ser_valid, busy, bit_idx, done, par_out
  );
endinterface

// File: rtl/piso_shift_ctrl.sv
// Full-duplex word serialiser: shifts a loaded word out one bit every DIV clocks
// while capturing ser_in on the same ticks, presenting the received word at completion.
module piso_shift_ctrl #(
  parameter int WIDTH      = 8,
  parameter int DIV        = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  piso_shift_ctrl_if.slave   bus
);
  localparam int IW   = $clog2(WIDTH);
  localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] shreg_reg;
  logic [IW-1:0]    bitcnt_reg;
  logic [DIVW-1:0]  divcnt_reg;
  logic [WIDTH-1:0] par_reg;
  logic             done_reg;

  logic             tick;
  logic             last_bit;
  logic             tx_bit;
  logic [WIDTH-1:0] shreg_next;

  assign tick     = (divcnt_reg == DIVW'(DIV - 1));
  assign last_bit = (bitcnt_reg == IW'(WIDTH - 1));

  // Received bits enter at the end opposite the transmit end, so the first
  // received bit finishes at the transmit-first position of the word.
  generate
    if (MSB_FIRST) begin : g_msb
      assign tx_bit     = shreg_reg[WIDTH-1];
      assign shreg_next = {shreg_reg[WIDTH-2:0], bus.ser_in};
    end else begin : g_lsb
      assign tx_bit     = shreg_reg[0];
      assign shreg_next = {bus.ser_in, shreg_reg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      shreg_reg  <= '0;
      bitcnt_reg <= '0;
      divcnt_reg <= '0;
      par_reg    <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.load_valid) begin
            shreg_reg  <= bus.load_data;
            bitcnt_reg <= '0;
            divcnt_reg <= '0;
            state_reg  <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            divcnt_reg <= '0;
            shreg_reg  <= shreg_next;
            if (last_bit) begin
              par_reg    <= shreg_next;
              done_reg   <= 1'b1;
              bitcnt_reg <= '0;
              state_reg  <= IDLE;
            end else begin
              bitcnt_reg <= bitcnt_reg + 1'b1;
            end
          end else begin
            divcnt_reg <= divcnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Status is forced inactive while rst is held so nothing looks live before the reset edge.
  assign bus.load_ready = !rst && (state_reg == IDLE);
  assign bus.busy       = !rst && (state_reg == SHIFT);
  assign bus.ser_valid  = bus.busy;
  assign bus.ser_out    = bus.busy ? tx_bit : IDLE_LEVEL;
  assign bus.bit_idx    = bitcnt_reg;
  assign bus.done       = done_reg;
  assign bus.par_out    = par_reg;
endmodule

// File: doc/piso_shift_ctrl.md
Name: piso_shift_ctrl

Overview:
- Parametrised serialiser/deserialiser. It is the successor to the fixed 4-bit parallel-in serial-out register that used a separate divider.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit every DIV clocks, MSB- or LSB-first.
- Captures ser_in on the same bit ticks, so a full word of received serial data is presented on par_out at completion (full-duplex, SPI-style).
- The bit-rate divider is internal; no derived clock is generated. All logic runs on clk.

Parameters:
- WIDTH, 8, word length in bits; legal range WIDTH >= 2.
- DIV, 4, clock cycles per serial bit; legal range DIV >= 1. DIV = 1 means one bit per clock.
- MSB_FIRST, 1, 1 = transmit d[WIDTH-1] first; 0 = transmit d[0] first.
- IDLE_LEVEL, 0, value driven on ser_out while not shifting.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block can accept a word.
- load_data  input  WIDTH  parallel word to transmit.
- ser_in  input  1  serial receive bit, sampled on bit ticks.
- ser_out  output  1  serial transmit bit.
- ser_valid  output  1  ser_out carries a data bit.
- busy  output  1  shift in progress.
- bit_idx  output  $clog2(WIDTH)  number of bits already completed in the current word.
- done  output  1  one-cycle pulse at word completion.
- par_out  output  WIDTH  last fully received word.

Behaviour:
- Reset (rst = 1 at a clock edge):
  - State goes to IDLE; shreg = 0, bitcnt = 0, divcnt = 0, par_out = 0, done = 0.
  - While rst is high: busy = 0, ser_valid = 0, ser_out = IDLE_LEVEL, load_ready = 0.
  - A reset during SHIFT aborts the word. No done pulse is generated and par_out is cleared.
- States: IDLE and SHIFT.
- IDLE:
  - load_ready = 1, busy = 0, ser_valid = 0, ser_out = IDLE_LEVEL.
  - Accept occurs when load_valid and load_ready are both high at an edge. On accept: shreg <= load_data, bitcnt <= 0, divcnt <= 0, state <= SHIFT.
  - load_valid while load_ready = 0 is ignored; nothing is queued.
- SHIFT:
  - load_ready = 0, busy = 1, ser_valid = 1.
  - ser_out = shreg[WIDTH-1] when MSB_FIRST = 1, otherwise shreg[0]. It is decoded combinationally from registers only and is stable for a whole bit period.
  - divcnt counts 0 to DIV-1. The tick condition is divcnt == DIV-1; on a tick divcnt wraps to 0.
- On each tick:
  - shreg shifts one position toward the transmit end. ser_in enters the vacated end: bit 0 when MSB_FIRST = 1, bit WIDTH-1 when MSB_FIRST = 0.
  - bitcnt increments.
  - If bitcnt == WIDTH-1 before the increment, the word is complete: par_out <= shifted shreg, done <= 1 for the next cycle, state <= IDLE, bitcnt <= 0.
- Timing and latency:
  - Each bit is held for exactly DIV cycles, so a word occupies WIDTH*DIV cycles.
  - The first bit is on ser_out in the cycle after the accept edge.
  - done is asserted in the first IDLE cycle, with busy = 0 and load_ready = 1 in that same cycle.
  - Back-to-back words: a load accepted in the done cycle gives a minimum gap of exactly one IDLE cycle on ser_valid.
- Receive ordering: the first received bit ends up at the transmit-first end of par_out. A loopback (ser_in = ser_out) therefore returns load_data unchanged for either MSB_FIRST setting.
- Outputs during SHIFT: par_out holds its previous value throughout and updates only at completion. bit_idx = bitcnt.
- Arithmetic: divcnt is $clog2(DIV) bits wide, with a minimum of 1 bit. No counter may exceed its terminal value.

Test Plan:
- Reset, then WIDTH=4, DIV=1, MSB_FIRST=1, load 4'b1011 with loopback.
  - ser_out reads 1,0,1,1 on cycles 1 through 4 after accept; busy is high for 4 cycles.
  - done pulses on cycle 5 and par_out = 4'b1011.
- WIDTH=8, DIV=4, MSB_FIRST=0, load 8'hA5, ser_in tied to 1.
  - ser_out is LSB-first: 1,0,1,0,0,1,0,1, each bit held 4 cycles, 32 busy cycles in total.
  - par_out = 8'hFF at done.
- Back-to-back: load_valid held high with words 8'h3C then 8'hC3.
  - The second word is accepted in the done cycle of the first, leaving exactly one cycle with ser_valid = 0 between words.
  - load_ready = 0 throughout each shift.
- Reset mid-word: assert rst after 3 bits of 8'hF0.
  - Next cycle: busy = 0, ser_out = IDLE_LEVEL, par_out = 0, and no done pulse.
  - A new load after reset transmits correctly.
- Handshake: pulse load_valid while busy.
  - The word is ignored, the current word is unaffected, and par_out reflects only the in-progress word.
